// File: rtl/notch_coef_ctrl_if.sv
// rtl/notch_coef_ctrl_if.sv - host configuration bus for the notch coefficient controller
interface notch_coef_ctrl_if #(
    parameter int W = 24
);
    logic                cfg_wr;
    logic [1:0]          cfg_addr;
    logic signed [W-1:0] cfg_wdata;
    logic                cfg_busy;
    logic                cfg_err;

    modport master (
        output cfg_wr, cfg_addr, cfg_wdata,
        input  cfg_busy, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_wdata,
        output cfg_busy, cfg_err
    );
endinterface

// File: rtl/notch_coef_ctrl.sv
// rtl/notch_coef_ctrl.sv - shadowed, stability-checked, gliding b1/a1/a2 coefficient controller
module notch_coef_ctrl #(
    parameter int W         = 24,
    parameter int FRAC      = 12,
    parameter int RAMP_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    notch_coef_ctrl_if.slave    cfg,
    input  logic                din_valid,
    output logic signed [W-1:0] b1,
    output logic signed [W-1:0] a1,
    output logic signed [W-1:0] a2,
    output logic                bypass,
    output logic                ramp_active
);
    localparam int CW = (RAMP_LOG2 > 0) ? RAMP_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << RAMP_LOG2) - 1);
    localparam logic signed [W+1:0] ONE = {{(W+1-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, PEND, RAMP} state_t;

    state_t              state;
    logic signed [W-1:0] sh_b1, sh_a1, sh_a2;
    logic signed [W:0]   dl_b1, dl_a1, dl_a2;
    logic [CW-1:0]       cnt;
    logic                byp_pend;
    logic                busy_q;
    logic                err_q;

    logic                wr_shadow, wr_ctrl, commit, err_set, err_clr, stable;
    logic signed [W+1:0] a1_x, a2_x, a1_abs;

    assign cfg.cfg_busy = busy_q;
    assign cfg.cfg_err  = err_q;

    // Per-coefficient step: magnitude shifted so the glide never overshoots the target.
    function automatic logic signed [W:0] glide_step(input logic signed [W-1:0] tgt,
                                                     input logic signed [W-1:0] cur);
        logic signed [W:0] d;
        logic [W:0]        mag;
        d   = {tgt[W-1], tgt} - {cur[W-1], cur};
        mag = d[W] ? -d : d;
        mag = mag >> RAMP_LOG2;
        return d[W] ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic signed [W-1:0] step_add(input logic signed [W-1:0] cur,
                                                     input logic signed [W:0]   dl);
        logic signed [W:0] sum;
        sum = {cur[W-1], cur} + dl;
        return sum[W-1:0];
    endfunction

    always_comb begin
        wr_shadow = cfg.cfg_wr && (cfg.cfg_addr != 2'd3);
        wr_ctrl   = cfg.cfg_wr && (cfg.cfg_addr == 2'd3);
        commit    = wr_ctrl && cfg.cfg_wdata[0];
        a1_x      = {{2{sh_a1[W-1]}}, sh_a1};
        a2_x      = {{2{sh_a2[W-1]}}, sh_a2};
        a1_abs    = a1_x[W+1] ? -a1_x : a1_x;
        stable    = !a2_x[W+1] && (a2_x < ONE) && (a1_abs < (ONE + a2_x));
        err_set   = (wr_shadow && busy_q) || (commit && (busy_q || !stable));
        err_clr   = wr_ctrl && cfg.cfg_wdata[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sh_b1       <= '0;
            sh_a1       <= '0;
            sh_a2       <= '0;
            dl_b1       <= '0;
            dl_a1       <= '0;
            dl_a2       <= '0;
            cnt         <= '0;
            b1          <= '0;
            a1          <= '0;
            a2          <= '0;
            byp_pend    <= 1'b1;
            bypass      <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ramp_active <= 1'b0;
        end else begin
            if (wr_shadow && !busy_q) begin
                case (cfg.cfg_addr)
                    2'd0:    sh_b1 <= cfg.cfg_wdata;
                    2'd1:    sh_a1 <= cfg.cfg_wdata;
                    default: sh_a2 <= cfg.cfg_wdata;
                endcase
            end
            if (wr_ctrl)
                byp_pend <= cfg.cfg_wdata[1];
            if (din_valid)
                bypass <= byp_pend;
            // A new error wins over a clear arriving in the same cycle.
            if (err_set)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (commit && stable) begin
                        state  <= PEND;
                        busy_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (din_valid) begin
                        dl_b1       <= glide_step(sh_b1, b1);
                        dl_a1       <= glide_step(sh_a1, a1);
                        dl_a2       <= glide_step(sh_a2, a2);
                        cnt         <= '0;
                        state       <= RAMP;
                        ramp_active <= 1'b1;
                    end
                end
                RAMP: begin
                    if (din_valid) begin
                        if (cnt == LAST) begin
                            b1          <= sh_b1;
                            a1          <= sh_a1;
                            a2          <= sh_a2;
                            state       <= IDLE;
                            busy_q      <= 1'b0;
                            ramp_active <= 1'b0;
                        end else begin
                            b1  <= step_add(b1, dl_b1);
                            a1  <= step_add(a1, dl_a1);
                            a2  <= step_add(a2, dl_a2);
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    ramp_active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_notch_coef_ctrl.sv
// tb/tb_notch_coef_ctrl.sv - directed and randomized checks of notch_coef_ctrl against a behavioural model
module tb_notch_coef_ctrl;
    localparam int W         = 24;
    localparam int FRAC      = 12;
    localparam int RAMP_LOG2 = 2;
    localparam int STEPS     = 1 << RAMP_LOG2;

    logic                clk = 1'b0;
    logic                rst;
    logic                din_valid;
    logic signed [W-1:0] b1, a1, a2;
    logic                bypass, ramp_active;

    notch_coef_ctrl_if #(.W(W)) cfg_if ();

    notch_coef_ctrl #(.W(W), .FRAC(FRAC), .RAMP_LOG2(RAMP_LOG2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if),
        .din_valid   (din_valid),
        .b1          (b1),
        .a1          (a1),
        .a2          (a2),
        .bypass      (bypass),
        .ramp_active (ramp_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 waiting for a sample, 2 gliding
    int m_live[3];
    int m_sh[3];
    int m_dl[3];
    int m_phase, m_steps;
    bit m_err, m_byp, m_byp_pend;

    task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit stable_m(int a1v, int a2v);
        int mag;
        mag = (a1v < 0) ? -a1v : a1v;
        return (a2v >= 0) && (a2v < (1 << FRAC)) && (mag < (1 << FRAC) + a2v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_live[i] = 0;
            m_sh[i]   = 0;
            m_dl[i]   = 0;
        end
        m_phase = 0; m_steps = 0;
        m_err = 1'b0; m_byp = 1'b1; m_byp_pend = 1'b1;
    endtask

    task automatic check_all(string ctx);
        check({ctx, ".b1"},   32'(b1), m_live[0]);
        check({ctx, ".a1"},   32'(a1), m_live[1]);
        check({ctx, ".a2"},   32'(a2), m_live[2]);
        check({ctx, ".byp"},  32'(bypass), 32'(m_byp));
        check({ctx, ".busy"}, 32'(cfg_if.cfg_busy), 32'(m_phase != 0));
        check({ctx, ".ramp"}, 32'(ramp_active), 32'(m_phase == 2));
        check({ctx, ".err"},  32'(cfg_if.cfg_err), 32'(m_err));
    endtask

    // One clock edge with optional host write and sample strobe; called at a negedge.
    task automatic edge_op(string ctx, bit wr, int addr, int data, bit dv);
        int  old_phase;
        bit  busy, fail;
        cfg_if.cfg_wr    = wr;
        cfg_if.cfg_addr  = 2'(addr);
        cfg_if.cfg_wdata = W'(data);
        din_valid        = dv;
        @(posedge clk);
        #1;
        cfg_if.cfg_wr = 1'b0;
        din_valid     = 1'b0;

        old_phase = m_phase;
        busy      = (old_phase != 0);
        if (dv) begin
            m_byp = m_byp_pend;
            if (old_phase == 1) begin
                for (int i = 0; i < 3; i++) m_dl[i] = (m_sh[i] - m_live[i]) / STEPS;
                m_steps = 0;
                m_phase = 2;
            end else if (old_phase == 2) begin
                m_steps++;
                for (int i = 0; i < 3; i++)
                    m_live[i] = (m_steps == STEPS) ? m_sh[i] : m_live[i] + m_dl[i];
                if (m_steps == STEPS) m_phase = 0;
            end
        end
        if (wr) begin
            if (addr < 3) begin
                if (busy) m_err = 1'b1;
                else      m_sh[addr] = data;
            end else begin
                fail = data[0] && (busy || !stable_m(m_sh[1], m_sh[2]));
                if (data[0] && !fail) m_phase = 1;
                m_byp_pend = data[1];
                if (fail)         m_err = 1'b1;
                else if (data[2]) m_err = 1'b0;
            end
        end
        check_all(ctx);
        @(negedge clk);
    endtask

    task automatic wr(int addr, int data);
        edge_op("wr", 1'b1, addr, data, 1'b0);
    endtask

    task automatic strobe();
        edge_op("dv", 1'b0, 0, 0, 1'b1);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) edge_op("idle", 1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
        @(negedge clk);
    endtask

    int exp_b1[4] = '{-1024, -2048, -3072, -4096};
    int exp_a1[4] = '{-983, -1966, -2949, -3932};
    int exp_a2[4] = '{943, 1886, 2829, 3775};

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb1, ra1, ra2, lim, ctrl;
        rst = 1'b1;
        din_valid = 1'b0;
        cfg_if.cfg_wr = 1'b0;
        cfg_if.cfg_addr = 2'd0;
        cfg_if.cfg_wdata = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle strobing leaves reset values in place
        for (int i = 0; i < 10; i++) begin
            strobe();
            idle(1);
        end

        // Directed glide to b1=-4096 a1=-3932 a2=3775
        wr(0, -4096); wr(1, -3932); wr(2, 3775); wr(3, 1);
        check("plan.pend_busy", 32'(cfg_if.cfg_busy), 1);
        strobe();
        check("plan.enter_ramp", 32'(ramp_active), 1);
        check("plan.enter_b1", 32'(b1), 0);
        for (int k = 0; k < 4; k++) begin
            idle(4);
            strobe();
            check($sformatf("plan.b1_%0d", k), 32'(b1), exp_b1[k]);
            check($sformatf("plan.a1_%0d", k), 32'(a1), exp_a1[k]);
            check($sformatf("plan.a2_%0d", k), 32'(a2), exp_a2[k]);
        end
        check("plan.done_busy", 32'(cfg_if.cfg_busy), 0);

        // Unstable commit
        wr(2, 4096); wr(3, 1);
        check("unstable.err", 32'(cfg_if.cfg_err), 1);
        check("unstable.a2_held", 32'(a2), 3775);
        wr(3, 4);
        check("unstable.clr", 32'(cfg_if.cfg_err), 0);

        // Mid-glide writes are dropped; bypass follows next strobe
        wr(0, 2000); wr(1, 500); wr(2, 1000); wr(3, 3);
        strobe();
        check("mid.byp_on", 32'(bypass), 1);
        strobe();
        wr(0, 100); wr(3, 1);
        check("mid.err", 32'(cfg_if.cfg_err), 1);
        wr(3, 0);
        strobe();
        check("mid.byp_off", 32'(bypass), 0);
        strobe(); strobe();
        check("mid.final_b1", 32'(b1), 2000);
        check("mid.final_a2", 32'(a2), 1000);
        check("mid.idle", 32'(cfg_if.cfg_busy), 0);

        // Commit coincident with a strobe
        wr(3, 4);
        wr(0, -500); wr(1, -100); wr(2, 200);
        edge_op("commit_dv", 1'b1, 3, 1, 1'b1);
        check("cdv.pend", 32'(cfg_if.cfg_busy), 1);
        check("cdv.not_ramp", 32'(ramp_active), 0);
        strobe();
        check("cdv.held_b1", 32'(b1), 2000);
        strobe();
        check("cdv.step_b1", 32'(b1), 1375);
        check("cdv.step_a1", 32'(a1), 350);
        strobe(); strobe(); strobe();

        // Reset mid-glide, then shadows must read back as zero via a commit
        wr(0, 800); wr(3, 1);
        strobe(); strobe(); strobe();
        do_reset();
        check("rst.byp", 32'(bypass), 1);
        check("rst.b1", 32'(b1), 0);
        wr(3, 1);
        for (int i = 0; i < 5; i++) strobe();
        check("rst.shadow_b1", 32'(b1), 0);

        // Randomized retunes with stray writes and gaps
        for (int it = 0; it < 30; it++) begin
            rb1 = int'($urandom_range(0, 16777215)) - 8388608;
            ra2 = int'($urandom_range(0, 4095));
            lim = 4095 + ra2;
            ra1 = int'($urandom_range(0, 2 * lim)) - lim;
            case ($urandom_range(0, 7))
                0: ra2 = 4096 + int'($urandom_range(0, 100));
                1: ra2 = -int'($urandom_range(1, 100));
                2: ra1 = ($urandom_range(0, 1) != 0) ? (4096 + ra2) : -(4096 + ra2);
                default: ;
            endcase
            wr(0, rb1); wr(1, ra1); wr(2, ra2);
            ctrl = 1 | (int'($urandom_range(0, 1)) << 1);
            wr(3, ctrl);
            for (int s = 0; s < 8 && m_phase != 0; s++) begin
                idle(int'($urandom_range(0, 3)));
                if ($urandom_range(0, 4) == 0)
                    wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
                strobe();
            end
            wr(3, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
